// File: rtl/banco_registros_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | banco_registros_pkg: shared sizes and the register-zero constant.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package banco_registros_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREG_DEF   = 2 ** ADDR_W_DEF;
  localparam int REG_CERO   = 0;
endpackage
`default_nettype wire

// File: rtl/banco_registros_marcador_ocupado.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | marcador_ocupado: one busy bit per register, set on issue, cleared |
// | on writeback (set wins). Rev 1.0                                   |
// +--------------------------------------------------------------------+
module marcador_ocupado
  import banco_registros_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rd1_addr_i,
  input  logic [ADDR_W-1:0] rd2_addr_i,
  output logic              busy1_o,
  output logic              busy2_o
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CERO = ADDR_W'(REG_CERO);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_i && (clr_addr_i != CERO)) busy_d[clr_addr_i] = 1'b0;
    // Applied after the clear so a newer writer issuing this cycle stays pending.
    if (set_i && (set_addr_i != CERO)) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy1_o = busy_q[rd1_addr_i] && (rd1_addr_i != CERO);
  assign busy2_o = busy_q[rd2_addr_i] && (rd2_addr_i != CERO);
endmodule
`default_nettype wire

// File: rtl/banco_registros.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | banco_registros: 2R/1W register file with pending-write stall.     |
// | Optional write-through bypass: BANCO_REGISTROS_BYPASS_EN. Rev 1.0  |
// +--------------------------------------------------------------------+
module banco_registros
  import banco_registros_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  output logic [DATA_W-1:0] Dato1,
  output logic [DATA_W-1:0] Dato2,
  input  logic              WE_WB,
  input  logic [ADDR_W-1:0] RD_WB,
  input  logic [DATA_W-1:0] Dato_WB,
  input  logic              ISSUE,
  input  logic [ADDR_W-1:0] RD_ISSUE,
  output logic              Stall
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CERO = ADDR_W'(REG_CERO);

  logic [DATA_W-1:0] regs_q [NREG];
  logic              wb_valid;
  logic              busy1;
  logic              busy2;
  logic              byp1;
  logic              byp2;

  assign wb_valid = WE_WB && (RD_WB != CERO);

  // Register 0 is reset to zero and never written, so it always reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_valid) begin
      regs_q[RD_WB] <= Dato_WB;
    end
  end

  marcador_ocupado #(.ADDR_W(ADDR_W)) u_marcador (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (ISSUE),
    .set_addr_i (RD_ISSUE),
    .clr_i      (WE_WB),
    .clr_addr_i (RD_WB),
    .rd1_addr_i (RS1),
    .rd2_addr_i (RS2),
    .busy1_o    (busy1),
    .busy2_o    (busy2)
  );

`ifdef BANCO_REGISTROS_BYPASS_EN
  assign byp1 = wb_valid && (RD_WB == RS1);
  assign byp2 = wb_valid && (RD_WB == RS2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign Dato1 = byp1 ? Dato_WB : regs_q[RS1];
  assign Dato2 = byp2 ? Dato_WB : regs_q[RS2];
  assign Stall = (busy1 && !byp1) || (busy2 && !byp2);
endmodule
`default_nettype wire

// File: tb/tb_banco_registros.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_banco_registros: directed self-checking bench for the register  |
// | file and scoreboard. Rev 1.0                                       |
// +--------------------------------------------------------------------+
module tb_banco_registros;
  logic        clk;
  logic        rst_n;
  logic [4:0]  RS1, RS2, RD_WB, RD_ISSUE;
  logic [31:0] Dato1, Dato2, Dato_WB;
  logic        WE_WB, ISSUE, Stall;

  int n_chk = 0;
  int n_err = 0;

  banco_registros dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RS1      (RS1),
    .RS2      (RS2),
    .Dato1    (Dato1),
    .Dato2    (Dato2),
    .WE_WB    (WE_WB),
    .RD_WB    (RD_WB),
    .Dato_WB  (Dato_WB),
    .ISSUE    (ISSUE),
    .RD_ISSUE (RD_ISSUE),
    .Stall    (Stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE_WB = 1'b0; RD_WB = '0; Dato_WB = '0;
    ISSUE = 1'b0; RD_ISSUE = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    RS1 = 5'd5; RS2 = 5'd31;
    idle();
    #2;
    chk("rst_dato1", Dato1, 32'h0);
    chk("rst_dato2", Dato2, 32'h0);
    chk("rst_stall", {31'h0, Stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_dato1", Dato1, 32'h0);

    // Write reg 5, then mark it pending, then reset asynchronously mid-cycle.
    WE_WB = 1'b1; RD_WB = 5'd5; Dato_WB = 32'hDEADBEEF;
    step();
    idle();
    ISSUE = 1'b1; RD_ISSUE = 5'd5;
    step();
    idle();
    @(negedge clk);
    chk("wr5_dato1", Dato1, 32'hDEADBEEF);
    chk("busy5_stall", {31'h0, Stall}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_dato1", Dato1, 32'h0);
    chk("async_rst_stall", {31'h0, Stall}, 32'h0);
    #1 rst_n = 1'b1;
    step();

    // Register zero: neither written nor marked busy.
    WE_WB = 1'b1; RD_WB = 5'd0; Dato_WB = 32'hFFFFFFFF;
    ISSUE = 1'b1; RD_ISSUE = 5'd0;
    RS1 = 5'd0; RS2 = 5'd0;
    step();
    idle();
    @(negedge clk);
    chk("r0_dato1", Dato1, 32'h0);
    chk("r0_stall", {31'h0, Stall}, 32'h0);

    // Basic writes (to non-busy registers).
    step();
    WE_WB = 1'b1; RD_WB = 5'd3; Dato_WB = 32'd2;
    step();
    WE_WB = 1'b1; RD_WB = 5'd4; Dato_WB = 32'd1;
    step();
    idle();
    RS1 = 5'd3; RS2 = 5'd4;
    @(negedge clk);
    chk("rd_r3", Dato1, 32'd2);
    chk("rd_r4", Dato2, 32'd1);
    chk("nobusy_stall", {31'h0, Stall}, 32'h0);

    // RAW hazard on reg 7.
    step();
    ISSUE = 1'b1; RD_ISSUE = 5'd7;
    RS1 = 5'd3; RS2 = 5'd4;
    @(negedge clk);
    chk("issue_cycle_stall", {31'h0, Stall}, 32'h0);
    step();
    idle();
    RS1 = 5'd7;
    @(negedge clk);
    chk("raw_stall_a", {31'h0, Stall}, 32'h1);
    step();
    @(negedge clk);
    chk("raw_stall_b", {31'h0, Stall}, 32'h1);
    step();
    WE_WB = 1'b1; RD_WB = 5'd7; Dato_WB = 32'h55;
    @(negedge clk);
`ifdef BANCO_REGISTROS_BYPASS_EN
    chk("wb_cycle_stall", {31'h0, Stall}, 32'h0);
    chk("wb_cycle_dato1", Dato1, 32'h55);
`else
    chk("wb_cycle_stall", {31'h0, Stall}, 32'h1);
    chk("wb_cycle_dato1", Dato1, 32'h0);
`endif
    step();
    idle();
    @(negedge clk);
    chk("after_wb_stall", {31'h0, Stall}, 32'h0);
    chk("after_wb_dato1", Dato1, 32'h55);

    // Simultaneous set/clear on reg 9: the new issue keeps it busy.
    step();
    RS1 = 5'd0; RS2 = 5'd9;
    ISSUE = 1'b1; RD_ISSUE = 5'd9;
    step();
    idle();
    @(negedge clk);
    chk("r9_busy_p2", {31'h0, Stall}, 32'h1);
    step();
    ISSUE = 1'b1; RD_ISSUE = 5'd9;
    WE_WB = 1'b1; RD_WB = 5'd9; Dato_WB = 32'h99;
    step();
    idle();
    @(negedge clk);
    chk("setclr_stall", {31'h0, Stall}, 32'h1);
    chk("setclr_dato2", Dato2, 32'h99);
    step();
    WE_WB = 1'b1; RD_WB = 5'd9; Dato_WB = 32'hA5A5_0009;
    step();
    idle();
    @(negedge clk);
    chk("r9_clear_stall", {31'h0, Stall}, 32'h0);
    chk("r9_final_dato2", Dato2, 32'hA5A5_0009);
    RS1 = 5'd5;
    #1;
    chk("r5_after_rst", Dato1, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
